// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the serial-MAC FIR filter: default geometry, bus
// address map, derived accumulator width and the controller state encoding.
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int NTAP_DEF = 8;   // taps, power of two, 2..32
    localparam int DW_DEF   = 8;   // input sample width (signed)
    localparam int CW_DEF   = 8;   // coefficient width (signed)

    // Wide enough for NTAP worst-case products (-2^(DW-1) * -2^(CW-1)).
    localparam int OW_DEF = DW_DEF + CW_DEF + $clog2(NTAP_DEF);

    localparam logic [15:0] COEF_BASE_DEF = 16'h0040;  // coefficient 0
    localparam logic [15:0] CLR_ADDR_DEF  = 16'h004F;  // write clears ovf

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// -----------------------------------------------------------------------------
// fir_coef_bank
// Coefficient storage for the serial-MAC FIR. Bus writes land in a shadow
// bank; a load strobe copies the whole shadow bank into the active bank that
// the MAC reads, so a write never disturbs a result in progress.
//
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   wr         bus write strobe
//   waddr      bus write address (coefficient k at COEF_BASE+k)
//   wdata      bus write data, wdata[CW-1:0] is the coefficient
//   load       copy shadow -> active (sample capture edge)
//   idx        active-bank read index
//   coef       active coefficient at idx (combinational)
//   clr        write to CLR_ADDR decoded this cycle
// -----------------------------------------------------------------------------
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int          NTAP      = NTAP_DEF,
    parameter int          CW        = CW_DEF,
    parameter logic [15:0] COEF_BASE = COEF_BASE_DEF,
    parameter logic [15:0] CLR_ADDR  = CLR_ADDR_DEF,
    localparam int         IW        = $clog2(NTAP)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr,
    input  logic [15:0]          waddr,
    input  logic [15:0]          wdata,
    input  logic                 load,
    input  logic [IW-1:0]        idx,
    output logic signed [CW-1:0] coef,
    output logic                 clr
);

    logic signed [CW-1:0] shadow [NTAP];
    logic signed [CW-1:0] active [NTAP];
    logic [15:0]          offset;
    logic                 hit;
    logic                 unused_wdata;

    // Addresses below COEF_BASE wrap to a large offset and fall outside the
    // range, so one unsigned compare covers both ends of the window.
    assign offset = waddr - COEF_BASE;
    assign hit    = wr && (offset < 16'(NTAP));
    assign clr    = wr && (waddr == CLR_ADDR);

    assign unused_wdata = ^wdata[15:CW];

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; this is what makes load pick up the old shadow value
    // when a bus write hits on the same edge.
    // NOTE: these small register banks are reset explicitly because the
    // filter must start from all-zero coefficients; a large RAM would not be.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NTAP; k++) shadow[k] <= '0;
        end else if (hit) begin
            shadow[offset[IW-1:0]] <= wdata[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NTAP; k++) active[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < NTAP; k++) active[k] <= shadow[k];
        end
    end

    assign coef = active[idx];

endmodule

// File: rtl/fir_serial_mac.sv
// -----------------------------------------------------------------------------
// fir_serial_mac
// Time-multiplexed NTAP-tap FIR filter built around a single multiplier-
// accumulator. A sample is accepted in IDLE, then NTAP MAC cycles walk the
// delay line, then OUT publishes the full-precision result with a one-cycle
// out_valid pulse. Samples arriving while busy are dropped and set ovf.
//
// Build option:
//   FIR_OFFSET_BIN_IN_EN  defined: din is offset binary (MSB inverted on entry)
//                         undefined: din is signed two's complement
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   wr          bus write strobe (shared with the DDS register bus)
//   waddr       bus write address
//   wdata       bus write data
//   in_valid    din qualifier
//   din         input sample
//   in_ready    high while a sample would be accepted (IDLE)
//   out_valid   one-cycle pulse, dout valid
//   dout        filtered sample, signed, held until the next result
//   ovf         sticky: a sample was dropped while busy; cleared via CLR_ADDR
// -----------------------------------------------------------------------------
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int          NTAP      = NTAP_DEF,
    parameter int          DW        = DW_DEF,
    parameter int          CW        = CW_DEF,
    parameter int          OW        = DW + CW + $clog2(NTAP),
    parameter logic [15:0] COEF_BASE = COEF_BASE_DEF,
    parameter logic [15:0] CLR_ADDR  = CLR_ADDR_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr,
    input  logic [15:0]          waddr,
    input  logic [15:0]          wdata,
    input  logic                 in_valid,
    input  logic [DW-1:0]        din,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [OW-1:0] dout,
    output logic                 ovf
);

    localparam int IW = $clog2(NTAP);
    localparam int PW = DW + CW;

    fir_state_t           state, state_nx;
    logic                 capture, mac_en, out_en, last_tap, overrun, clr;
    logic [IW-1:0]        idx;
    logic signed [DW-1:0] x [NTAP];
    logic signed [DW-1:0] din_s, x_sel;
    logic signed [CW-1:0] coef_sel;
    logic signed [PW-1:0] prod;
    logic signed [OW-1:0] prod_ext, acc;

`ifdef FIR_OFFSET_BIN_IN_EN
    assign din_s = {~din[DW-1], din[DW-2:0]};
`else
    assign din_s = din;
`endif

    fir_coef_bank #(
        .NTAP      (NTAP),
        .CW        (CW),
        .COEF_BASE (COEF_BASE),
        .CLR_ADDR  (CLR_ADDR)
    ) u_coef_bank (
        .clk   (clk),
        .rstn  (rstn),
        .wr    (wr),
        .waddr (waddr),
        .wdata (wdata),
        .load  (capture),
        .idx   (idx),
        .coef  (coef_sel),
        .clr   (clr)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    assign last_tap = (idx == IW'(NTAP - 1));

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        mac_en   = 1'b0;
        out_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    capture  = 1'b1;
                    state_nx = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (last_tap) state_nx = ST_OUT;
            end
            ST_OUT: begin
                out_en   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign in_ready = (state == ST_IDLE);
    assign overrun  = in_valid && (state != ST_IDLE);

    // --------------------------------------------------------- delay line
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NTAP; k++) x[k] <= '0;
        end else if (capture) begin
            x[0] <= din_s;
            for (int k = 1; k < NTAP; k++) x[k] <= x[k-1];
        end
    end

    // ----------------------------------------------------------------- MAC
    // Operands are sign-extended to the full product width by hand; the low
    // PW bits of the unsigned product are then the exact signed product.
    assign x_sel    = x[idx];
    assign prod     = {{CW{x_sel[DW-1]}}, x_sel} * {{DW{coef_sel[CW-1]}}, coef_sel};
    assign prod_ext = {{(OW - PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc       <= '0;
            idx       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_en;
            if (capture) begin
                acc <= '0;
                idx <= '0;
            end else if (mac_en) begin
                acc <= acc + prod_ext;
                idx <= idx + IW'(1);
            end
            if (out_en) dout <= acc;
        end
    end

    // ------------------------------------------------------------ overrun
    // A drop and a clear on the same edge leave the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        ovf <= 1'b0;
        else if (overrun) ovf <= 1'b1;
        else if (clr)     ovf <= 1'b0;
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
`timescale 1ns/1ps
module tb_fir_serial_mac;

    localparam int NTAP = 8;
    localparam int DW   = 8;
    localparam int OW   = 19;
    localparam int LAT  = NTAP + 1;   // accept edge -> out_valid visible

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            wr = 1'b0;
    logic [15:0]     waddr = '0;
    logic [15:0]     wdata = '0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   din = '0;
    logic            in_ready, out_valid, ovf;
    logic [OW-1:0]   dout;

    fir_serial_mac dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr        (wr),
        .waddr     (waddr),
        .wdata     (wdata),
        .in_valid  (in_valid),
        .din       (din),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .dout      (dout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] dout;
        int            t_acc;
    } exp_t;

    typedef struct {
        logic [DW-1:0] din;
        logic [OW-1:0] exp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t imp_tab[9];
    vec_t max_tab[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard consumer: every out_valid pops one expectation.
    always @(posedge clk) begin
        #2;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("dout", 32'(dout), 32'(mon_e.dout));
                check("latency", 32'(cyc - mon_e.t_acc), 32'(LAT));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        wr = 1'b1; waddr = a; wdata = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic expect_out(input logic [OW-1:0] e);
        exp_t r;
        r.dout  = e;
        r.t_acc = cyc + 1;
        sb.push_back(r);
    endtask

    // One sample at minimum legal spacing (NTAP+2 clocks).
    task automatic send(input logic [DW-1:0] d, input logic [OW-1:0] e);
        in_valid = 1'b1; din = d;
        expect_out(e);
        tick();
        in_valid = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        imp_tab = '{'{8'h01, 19'd1}, '{8'h00, 19'd2}, '{8'h00, 19'd3},
                    '{8'h00, 19'd4}, '{8'h00, 19'd5}, '{8'h00, 19'd6},
                    '{8'h00, 19'd7}, '{8'h00, 19'd8}, '{8'h00, 19'd0}};
        max_tab = '{'{8'h80, 19'd16384}, '{8'h80, 19'd32768},
                    '{8'h80, 19'd49152}, '{8'h80, 19'd65536},
                    '{8'h80, 19'd81920}, '{8'h80, 19'd98304},
                    '{8'h80, 19'd114688}, '{8'h80, 19'h20000}};

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rstn = 1'b1;
        tick();

        // Impulse: coefficients 1..8, upper wdata bits are junk; writes just
        // outside the window must be ignored.
        for (int k = 0; k < NTAP; k++)
            bus_write(16'(16'h0040 + k), {8'hA5, 8'(k + 1)});
        bus_write(16'h0048, 16'h007F);
        bus_write(16'h003F, 16'h007F);
        for (int i = 0; i < 9; i++) send(imp_tab[i].din, imp_tab[i].exp);
        drain();
        check("ovf_min_spacing", 32'(ovf), 32'd0);

        // Max magnitude: all -128 * -128
        for (int k = 0; k < NTAP; k++) bus_write(16'(16'h0040 + k), 16'h0080);
        for (int i = 0; i < 8; i++) send(max_tab[i].din, max_tab[i].exp);
        drain();

        // Overrun: second pulse one clock later is dropped
        in_valid = 1'b1; din = 8'h00;
        expect_out(19'd114688);
        tick();
        check("in_ready_busy", 32'(in_ready), 32'd0);
        din = 8'h55;
        tick();
        in_valid = 1'b0;
        check("ovf_set", 32'(ovf), 32'd1);
        drain();
        bus_write(16'h004F, 16'h1234);
        check("ovf_clr", 32'(ovf), 32'd0);

        // Overrun on the same edge as the clear: set wins
        in_valid = 1'b1; din = 8'h00;
        expect_out(19'd98304);
        tick();
        din = 8'h7F; wr = 1'b1; waddr = 16'h004F; wdata = 16'h0000;
        tick();
        in_valid = 1'b0; wr = 1'b0;
        check("ovf_set_wins", 32'(ovf), 32'd1);
        drain();

        // Write/capture collision: coef0=1, others 0, delay line flushed
        bus_write(16'h0040, 16'h0001);
        for (int k = 1; k < NTAP; k++) bus_write(16'(16'h0040 + k), 16'h0000);
        for (int i = 0; i < NTAP; i++) send(8'h00, 19'd0);
        in_valid = 1'b1; din = 8'h01;
        wr = 1'b1; waddr = 16'h0040; wdata = 16'h0005;
        expect_out(19'd1);
        tick();
        in_valid = 1'b0; wr = 1'b0;
        repeat (LAT) tick();
        send(8'h01, 19'd5);
        drain();

        // Mid-operation reset: in-flight result must never appear
        in_valid = 1'b1; din = 8'h01;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rstn = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (15) tick();
        send(8'h01, 19'd0);
        bus_write(16'h0040, 16'h0003);
        send(8'h02, 19'd6);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
